au_addsub_mp: RTL and testbench

- Multi-precision adder-subtractor sequencer for the arithmetic-unit library.
- Streams operands of arbitrary length as WIDTH-bit limbs, least significant limb first, through one limb-wide add/sub datapath.
- Chains carry/borrow between cycles and reports the two's-complement overflow flag and carry-out on the final limb.
- Sits upstream of result consumers; valid/ready on both sides, one registered output stage.

---
 rtl/au_addsub_mp.sv | 179 +++++++++++++++++
 tb/tb_au_addsub_mp.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_addsub_mp.sv
// au_addsub_mp: multi-precision adder-subtractor sequencer.
// Operands stream in as WIDTH-bit limbs, least significant first, through one
// limb-wide add/sub datapath. Carry/borrow chains between limbs; carry-out and
// two's-complement overflow are reported with the final limb. One registered
// output stage with valid/ready on both sides.
// Optional feature macro: AU_MP_ZERO_FLAG_EN (adds out_z, all-limbs-zero flag).
module au_addsub_mp #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_LIMBS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_add_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_last,
  output logic             out_co,
  output logic             out_v,
  output logic             out_err
`ifdef AU_MP_ZERO_FLAG_EN
  ,
  output logic             out_z
`endif
);

  localparam int unsigned CW = $clog2(MAX_LIMBS + 1);

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic             as_q, as_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_s_q, out_s_d;
  logic             out_last_q, out_last_d;
  logic             out_co_q, out_co_d;
  logic             out_v_q, out_v_d;
  logic             out_err_q, out_err_d;
`ifdef AU_MP_ZERO_FLAG_EN
  logic             nz_q, nz_d;
  logic             out_z_q, out_z_d;
`endif

  logic             accept;
  logic             is_first;
  logic             op_sub;
  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             c_out;
  logic             c_msb;
  logic             forced;
  logic             final_limb;

  // Limb datapath: operand select, add, carry and overflow extraction.
  always_comb begin
    accept     = in_valid & in_ready;
    is_first   = (state_q == ST_FIRST);
    op_sub     = is_first ? in_add_sub : as_q;
    cin        = is_first ? (in_ci ^ in_add_sub) : carry_q;
    b_eff      = in_b ^ {WIDTH{op_sub}};
    sum        = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    c_out      = sum[WIDTH];
    // Carry into the MSB recovered from the MSB sum bit; equals cin when WIDTH=1.
    c_msb      = sum[WIDTH-1] ^ in_a[WIDTH-1] ^ b_eff[WIDTH-1];
    forced     = (count_q == CW'(MAX_LIMBS - 1));
    final_limb = in_last | forced;
  end

  // Next-state: sequencer state, carry chain, limb count and output stage.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    count_d     = count_q;
    as_d        = as_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_last_d  = out_last_q;
    out_co_d    = out_co_q;
    out_v_d     = out_v_q;
    out_err_d   = out_err_q;
`ifdef AU_MP_ZERO_FLAG_EN
    nz_d        = nz_q;
    out_z_d     = out_z_q;
`endif

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_s_d     = sum[WIDTH-1:0];
      out_last_d  = final_limb;
      out_co_d    = final_limb & c_out;
      out_v_d     = final_limb & (c_msb ^ c_out);
      out_err_d   = final_limb & ~in_last;
`ifdef AU_MP_ZERO_FLAG_EN
      out_z_d     = final_limb & ~(nz_q | (|sum[WIDTH-1:0]));
`endif
      if (final_limb) begin
        state_d = ST_FIRST;
        carry_d = 1'b0;
        count_d = '0;
`ifdef AU_MP_ZERO_FLAG_EN
        nz_d    = 1'b0;
`endif
      end else begin
        state_d = ST_MID;
        carry_d = c_out;
        count_d = count_q + CW'(1);
        if (is_first) begin
          as_d = in_add_sub;
        end
`ifdef AU_MP_ZERO_FLAG_EN
        nz_d    = nz_q | (|sum[WIDTH-1:0]);
`endif
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FIRST;
      carry_q     <= 1'b0;
      count_q     <= '0;
      as_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_last_q  <= 1'b0;
      out_co_q    <= 1'b0;
      out_v_q     <= 1'b0;
      out_err_q   <= 1'b0;
`ifdef AU_MP_ZERO_FLAG_EN
      nz_q        <= 1'b0;
      out_z_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      as_q        <= as_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_last_q  <= out_last_d;
      out_co_q    <= out_co_d;
      out_v_q     <= out_v_d;
      out_err_q   <= out_err_d;
`ifdef AU_MP_ZERO_FLAG_EN
      nz_q        <= nz_d;
      out_z_q     <= out_z_d;
`endif
    end
  end

  assign in_ready  = ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_last  = out_last_q;
  assign out_co    = out_co_q;
  assign out_v     = out_v_q;
  assign out_err   = out_err_q;
`ifdef AU_MP_ZERO_FLAG_EN
  assign out_z     = out_z_q;
`endif

endmodule

// File: tb/tb_au_addsub_mp.sv
// Self-checking bench for au_addsub_mp (WIDTH=8, MAX_LIMBS=4).
// Reference model works on whole operands as integers; expected limbs go to a
// queue that the output monitor consumes on every output handshake.
module tb_au_addsub_mp;

  localparam int unsigned W  = 8;
  localparam int unsigned ML = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ci = 1'b0;
  logic         in_add_sub = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_s;
  logic         out_last;
  logic         out_co;
  logic         out_v;
  logic         out_err;
`ifdef AU_MP_ZERO_FLAG_EN
  logic         out_z;
`endif

  au_addsub_mp #(.WIDTH(W), .MAX_LIMBS(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .in_add_sub(in_add_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_last  (out_last),
    .out_co    (out_co),
    .out_v     (out_v),
    .out_err   (out_err)
`ifdef AU_MP_ZERO_FLAG_EN
    ,
    .out_z     (out_z)
`endif
  );

  typedef struct {
    logic [7:0] s;
    logic       last;
    logic       co;
    logic       v;
    logic       err;
    logic       z;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic stall = 1'b0;
  logic rand_mode = 1'b0;

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: held low while stalling, random in random mode.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = stall ? 1'b0 : (rand_mode ? 1'($urandom) : 1'b1);
  end

  // Output monitor: every handshake must match the next expected limb.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_s), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_s", 64'(out_s), 64'(e.s));
        check("out_last", 64'(out_last), 64'(e.last));
        check("out_co", 64'(out_co), 64'(e.co));
        check("out_v", 64'(out_v), 64'(e.v));
        check("out_err", 64'(out_err), 64'(e.err));
`ifdef AU_MP_ZERO_FLAG_EN
        check("out_z", 64'(out_z), 64'(e.z));
`endif
      end
    end
  end

  // Whole-operand reference: integer add/sub, carry/no-borrow, signed overflow.
  task automatic model_op(input int n, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic as, input logic has_last);
    longint unsigned mask, ua, ub, r;
    longint          lim, sa, sb, tr;
    logic            co, v;
    exp_t            e;
    mask = (64'd1 << (8 * n)) - 64'd1;
    ua   = 64'(a) & mask;
    ub   = 64'(b) & mask;
    lim  = longint'(64'd1 << (8 * n - 1));
    sa   = (longint'(ua) >= lim) ? longint'(ua) - 2 * lim : longint'(ua);
    sb   = (longint'(ub) >= lim) ? longint'(ub) - 2 * lim : longint'(ub);
    if (!as) begin
      r  = ua + ub + 64'(ci);
      co = ((r >> (8 * n)) != 0);
      tr = sa + sb + longint'(ci);
    end else begin
      r  = ua - ub - 64'(ci);
      co = (ua >= ub + 64'(ci));
      tr = sa - sb - longint'(ci);
    end
    r = r & mask;
    v = (tr < -lim) || (tr >= lim);
    for (int i = 0; i < n; i++) begin
      e.s    = 8'(r >> (8 * i));
      e.last = (i == n - 1);
      e.co   = (i == n - 1) ? co : 1'b0;
      e.v    = (i == n - 1) ? v : 1'b0;
      e.err  = (i == n - 1) ? ~has_last : 1'b0;
      e.z    = (i == n - 1) ? (r == 0) : 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_limb(input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic as, input logic last);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_ci = ci;
    in_add_sub = as;
    in_last = last;
    @(negedge clk);
    while (!in_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Drive one operand; later limbs carry random ci/add_sub which must be ignored.
  task automatic send_op(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic as, input logic has_last);
    for (int i = 0; i < n; i++) begin
      send_limb(8'(a >> (8 * i)), 8'(b >> (8 * i)),
                (i == 0) ? ci : 1'($urandom), (i == 0) ? as : 1'($urandom),
                has_last && (i == n - 1));
    end
    in_valid = 1'b0;
  endtask

  task automatic op(input int n, input logic [31:0] a, input logic [31:0] b,
                    input logic ci, input logic as, input logic has_last);
    model_op(n, a, b, ci, as, has_last);
    send_op(n, a, b, ci, as, has_last);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_s", 64'(out_s), 64'd0);
    check("rst_flags", 64'({out_last, out_co, out_v, out_err}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic cases.
    op(2, 32'h01FF, 32'h0001, 1'b0, 1'b0, 1'b1);
    op(2, 32'h0000, 32'h0001, 1'b0, 1'b1, 1'b1);
    op(2, 32'h0005, 32'h0003, 1'b0, 1'b1, 1'b1);
    op(2, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b1);
    op(2, 32'h8000, 32'h0001, 1'b0, 1'b1, 1'b1);
    op(1, 32'h7F, 32'h00, 1'b1, 1'b0, 1'b1);
    op(3, 32'hFFFFFF, 32'h000000, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Backpressure: output must hold while out_ready is low.
    stall = 1'b1;
    @(posedge clk);
    #1;
    model_op(2, 32'h1234, 32'h1111, 1'b0, 1'b0, 1'b1);
    send_limb(8'h34, 8'h11, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_a = 8'h12;
    in_b = 8'h11;
    in_ci = 1'b1;
    in_add_sub = 1'b1;
    in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_s", 64'(out_s), 64'h45);
    end
    stall = 1'b0;
    send_limb(8'h12, 8'h11, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Reset mid-operand drops the pending limb and partial state.
    stall = 1'b1;
    @(posedge clk);
    #1;
    send_limb(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_s", 64'(out_s), 64'd0);
    check("mid_rst_flags", 64'({out_last, out_co, out_v, out_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #1;
    op(1, 32'h10, 32'h20, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // Truncation at MAX_LIMBS, then a fresh operand with its own ci/add_sub.
    op(4, 32'h01010101, 32'h01010101, 1'b0, 1'b0, 1'b0);
    op(1, 32'h01, 32'h01, 1'b1, 1'b1, 1'b1);
    wait_drain();

`ifdef AU_MP_ZERO_FLAG_EN
    op(2, 32'h0100, 32'h0100, 1'b0, 1'b1, 1'b1);
    op(2, 32'h0100, 32'h00FF, 1'b0, 1'b1, 1'b1);
    wait_drain();
`endif

    // Randomized operands with random downstream backpressure.
    rand_mode = 1'b1;
    for (int t = 0; t < 60; t++) begin
      int n;
      n = int'($urandom_range(1, ML));
      op(n, $urandom, (t % 7 == 0) ? 32'h0 : $urandom, 1'($urandom), 1'($urandom),
         (n < int'(ML)) ? 1'b1 : 1'($urandom));
    end
    wait_drain();
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
